// File: rtl/beta_pkg.sv
// Shared types and constants for the Beta CPU decode and execute stages.
package beta_pkg;

    // ALU function codes, shared with the ALU.
    typedef enum logic [5:0] {
        FnCmpeq = 6'b000011,
        FnCmplt = 6'b000101,
        FnCmple = 6'b000111,
        FnAdd   = 6'b010000,
        FnSub   = 6'b010001,
        FnShl   = 6'b110000,
        FnShr   = 6'b110001,
        FnSra   = 6'b110011,
        FnAfn   = 6'b101010,
        FnAnd   = 6'b101000,
        FnOr    = 6'b101110,
        FnXor   = 6'b100110
    } alu_fn_t;

    typedef enum logic [1:0] {
        WdselPc  = 2'd0,
        WdselAlu = 2'd1,
        WdselMem = 2'd2
    } wdsel_t;

    typedef enum logic [1:0] {
        BrNone = 2'd0,
        BrJmp  = 2'd1,
        BrBeq  = 2'd2,
        BrBne  = 2'd3
    } br_t;

    localparam logic [5:0] OpLd    = 6'h18;
    localparam logic [5:0] OpSt    = 6'h19;
    localparam logic [5:0] OpJmp   = 6'h1B;
    localparam logic [5:0] OpBeq   = 6'h1C;
    localparam logic [5:0] OpBne   = 6'h1D;
    localparam logic [5:0] OpLdr   = 6'h1F;
    localparam logic [5:0] OpAdd   = 6'h20;
    localparam logic [5:0] OpSub   = 6'h21;
    localparam logic [5:0] OpCmpeq = 6'h24;
    localparam logic [5:0] OpCmplt = 6'h25;
    localparam logic [5:0] OpCmple = 6'h26;
    localparam logic [5:0] OpAnd   = 6'h28;
    localparam logic [5:0] OpOr    = 6'h29;
    localparam logic [5:0] OpXor   = 6'h2A;
    localparam logic [5:0] OpShl   = 6'h2C;
    localparam logic [5:0] OpShr   = 6'h2D;
    localparam logic [5:0] OpSra   = 6'h2E;

    // Exception pointer register, written with PC+4 on an illegal-opcode trap.
    localparam logic [4:0] XpReg = 5'd30;

    typedef struct packed {
        alu_fn_t     fn;
        logic        bsel;
        logic        asel;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rc;
        logic [31:0] lit;
        logic        werf;
        wdsel_t      wdsel;
        logic        mem_rd;
        logic        mem_wr;
        br_t         br;
        logic        illop;
    } decode_t;

endpackage

// File: rtl/beta_op_decoder.sv
// Combinational opcode decoder: instruction word to decoded control struct.
module beta_op_decoder
    import beta_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [5:0] opcode;
    alu_fn_t    alu_fn;
    logic       alu_ok;

    assign opcode = instr[31:26];

    // ALU function for the OP/OPC classes; OPC is folded onto OP by forcing bit 4 low.
    always_comb begin
        alu_fn = FnAdd;
        alu_ok = 1'b1;
        case ({2'b10, opcode[3:0]})
            OpAdd:   alu_fn = FnAdd;
            OpSub:   alu_fn = FnSub;
            OpCmpeq: alu_fn = FnCmpeq;
            OpCmplt: alu_fn = FnCmplt;
            OpCmple: alu_fn = FnCmple;
            OpAnd:   alu_fn = FnAnd;
            OpOr:    alu_fn = FnOr;
            OpXor:   alu_fn = FnXor;
            OpShl:   alu_fn = FnShl;
            OpShr:   alu_fn = FnShr;
            OpSra:   alu_fn = FnSra;
            default: alu_ok = 1'b0;
        endcase
    end

    // Main decode: register fields pass through unless an opcode overrides them.
    always_comb begin
        dec     = '0;
        dec.fn  = FnAdd;
        dec.ra  = instr[20:16];
        dec.rb  = instr[15:11];
        dec.rc  = instr[25:21];
        dec.lit = {{16{instr[15]}}, instr[15:0]};
        case (opcode)
            OpLd: begin
                dec.bsel   = 1'b1;
                dec.mem_rd = 1'b1;
                dec.werf   = 1'b1;
                dec.wdsel  = WdselMem;
            end
            OpSt: begin
                dec.bsel   = 1'b1;
                dec.mem_wr = 1'b1;
                // Store data is read through the B port from rc.
                dec.rb     = instr[25:21];
            end
            OpLdr: begin
                dec.fn     = FnAfn;
                dec.asel   = 1'b1;
                dec.mem_rd = 1'b1;
                dec.werf   = 1'b1;
                dec.wdsel  = WdselMem;
            end
            OpJmp: begin
                dec.werf  = 1'b1;
                dec.wdsel = WdselPc;
                dec.br    = BrJmp;
            end
            OpBeq: begin
                dec.werf  = 1'b1;
                dec.wdsel = WdselPc;
                dec.br    = BrBeq;
            end
            OpBne: begin
                dec.werf  = 1'b1;
                dec.wdsel = WdselPc;
                dec.br    = BrBne;
            end
            default: begin
                if (opcode[5] && alu_ok) begin
                    dec.fn    = alu_fn;
                    dec.bsel  = opcode[4];
                    dec.werf  = 1'b1;
                    dec.wdsel = WdselAlu;
                end else begin
                    dec.illop = 1'b1;
                    dec.rc    = XpReg;
                    dec.werf  = 1'b1;
                    dec.wdsel = WdselPc;
                end
            end
        endcase
    end

endmodule

// File: rtl/beta_decode.sv
// Beta decode stage: one-entry pipeline buffer between IF and EX with flush.
module beta_decode
    import beta_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_fn,
    output logic            out_bsel,
    output logic            out_asel,
    output logic [4:0]      out_ra,
    output logic [4:0]      out_rb,
    output logic [4:0]      out_rc,
    output logic [31:0]     out_lit,
    output logic [PC_W-1:0] out_pc,
    output logic            out_werf,
    output logic [1:0]      out_wdsel,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic [1:0]      out_br,
    output logic            out_illop
);

    decode_t         dec;
    decode_t         ent_q;
    logic [PC_W-1:0] pc_q;
    logic            valid_q;
    logic            valid_d;
    logic            accept;

    beta_op_decoder u_op_decoder (
        .instr (in_instr),
        .dec   (dec)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Buffer occupancy: flush wins, then a new accept, then a drain.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Valid flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload register; loads only on accept so it stays stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q <= '0;
            pc_q  <= '0;
        end else if (accept) begin
            ent_q <= dec;
            pc_q  <= in_pc;
        end
    end

    assign out_valid  = valid_q;
    assign out_fn     = ent_q.fn;
    assign out_bsel   = ent_q.bsel;
    assign out_asel   = ent_q.asel;
    assign out_ra     = ent_q.ra;
    assign out_rb     = ent_q.rb;
    assign out_rc     = ent_q.rc;
    assign out_lit    = ent_q.lit;
    assign out_pc     = pc_q;
    assign out_werf   = ent_q.werf;
    assign out_wdsel  = ent_q.wdsel;
    assign out_mem_rd = ent_q.mem_rd;
    assign out_mem_wr = ent_q.mem_wr;
    assign out_br     = ent_q.br;
    assign out_illop  = ent_q.illop;

endmodule

// File: tb/tb_beta_decode.sv
// Self-checking bench for beta_decode: directed test-plan cases plus randomized traffic.
module tb_beta_decode;

    localparam int unsigned PC_W = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      out_fn;
    logic            out_bsel;
    logic            out_asel;
    logic [4:0]      out_ra;
    logic [4:0]      out_rb;
    logic [4:0]      out_rc;
    logic [31:0]     out_lit;
    logic [PC_W-1:0] out_pc;
    logic            out_werf;
    logic [1:0]      out_wdsel;
    logic            out_mem_rd;
    logic            out_mem_wr;
    logic [1:0]      out_br;
    logic            out_illop;

    beta_decode #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_fn     (out_fn),
        .out_bsel   (out_bsel),
        .out_asel   (out_asel),
        .out_ra     (out_ra),
        .out_rb     (out_rb),
        .out_rc     (out_rc),
        .out_lit    (out_lit),
        .out_pc     (out_pc),
        .out_werf   (out_werf),
        .out_wdsel  (out_wdsel),
        .out_mem_rd (out_mem_rd),
        .out_mem_wr (out_mem_wr),
        .out_br     (out_br),
        .out_illop  (out_illop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  fn;
        logic        bsel;
        logic        asel;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rc;
        logic [31:0] lit;
        logic        werf;
        logic [1:0]  wdsel;
        logic        mem_rd;
        logic        mem_wr;
        logic [1:0]  br;
        logic        illop;
    } exp_t;

    int unsigned     n_checks = 0;
    int unsigned     n_fail   = 0;
    logic            m_valid;
    exp_t            m_ent;
    logic [PC_W-1:0] m_pc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode built from the opcode tables: class by opcode range, then ALU sub-code.
    function automatic exp_t model_decode(input logic [31:0] ins);
        exp_t        d;
        int          op;
        int          sub;
        logic        ill;
        logic [15:0] l;
        op  = int'(ins[31:26]);
        sub = op % 16;
        l   = ins[15:0];
        ill = 1'b0;
        d        = '0;
        d.fn     = 6'b010000;
        d.ra     = ins[20:16];
        d.rb     = ins[15:11];
        d.rc     = ins[25:21];
        d.lit    = l[15] ? {16'hFFFF, l} : {16'h0000, l};
        if (op >= 32) begin
            d.bsel  = (op >= 48);
            d.werf  = 1'b1;
            d.wdsel = 2'd1;
            case (sub)
                0:       d.fn = 6'b010000;
                1:       d.fn = 6'b010001;
                4:       d.fn = 6'b000011;
                5:       d.fn = 6'b000101;
                6:       d.fn = 6'b000111;
                8:       d.fn = 6'b101000;
                9:       d.fn = 6'b101110;
                10:      d.fn = 6'b100110;
                12:      d.fn = 6'b110000;
                13:      d.fn = 6'b110001;
                14:      d.fn = 6'b110011;
                default: ill = 1'b1;
            endcase
        end else if (op == 24) begin
            d.bsel = 1'b1; d.mem_rd = 1'b1; d.werf = 1'b1; d.wdsel = 2'd2;
        end else if (op == 25) begin
            d.bsel = 1'b1; d.mem_wr = 1'b1; d.rb = ins[25:21];
        end else if (op == 31) begin
            d.fn = 6'b101010; d.asel = 1'b1; d.mem_rd = 1'b1; d.werf = 1'b1; d.wdsel = 2'd2;
        end else if (op >= 27 && op <= 29) begin
            d.werf = 1'b1; d.wdsel = 2'd0; d.br = 2'(op - 26);
        end else begin
            ill = 1'b1;
        end
        if (ill) begin
            d.fn = 6'b010000; d.bsel = 1'b0; d.asel = 1'b0; d.illop = 1'b1; d.rc = 5'd30;
            d.werf = 1'b1; d.wdsel = 2'd0; d.mem_rd = 1'b0; d.mem_wr = 1'b0; d.br = 2'd0;
        end
        return d;
    endfunction

    task automatic compare_outputs();
        check_eq("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check_eq("fn", 64'(out_fn), 64'(m_ent.fn));
            check_eq("bsel", 64'(out_bsel), 64'(m_ent.bsel));
            check_eq("asel", 64'(out_asel), 64'(m_ent.asel));
            check_eq("ra", 64'(out_ra), 64'(m_ent.ra));
            check_eq("rb", 64'(out_rb), 64'(m_ent.rb));
            check_eq("rc", 64'(out_rc), 64'(m_ent.rc));
            check_eq("lit", 64'(out_lit), 64'(m_ent.lit));
            check_eq("werf", 64'(out_werf), 64'(m_ent.werf));
            check_eq("wdsel", 64'(out_wdsel), 64'(m_ent.wdsel));
            check_eq("mem_rd", 64'(out_mem_rd), 64'(m_ent.mem_rd));
            check_eq("mem_wr", 64'(out_mem_wr), 64'(m_ent.mem_wr));
            check_eq("br", 64'(out_br), 64'(m_ent.br));
            check_eq("illop", 64'(out_illop), 64'(m_ent.illop));
            check_eq("pc", 64'(out_pc), 64'(m_pc));
        end
    endtask

    // One clock cycle: drive after a falling edge, advance the model, compare at the next fall.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                         input logic ordy, input logic fl);
        logic acc;
        logic n_valid;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_eq("in_ready", 64'(in_ready), 64'(!m_valid || ordy));
        acc     = v && (!m_valid || ordy) && !fl;
        n_valid = fl ? 1'b0 : (acc ? 1'b1 : (ordy ? 1'b0 : m_valid));
        @(posedge clk);
        m_valid = n_valid;
        if (acc) begin
            m_ent = model_decode(ins);
            m_pc  = pc;
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic check_payload_zero();
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_fn", 64'(out_fn), 64'd0);
        check_eq("rst_payload", 64'({out_bsel, out_asel, out_ra, out_rb, out_rc, out_werf,
                 out_wdsel, out_mem_rd, out_mem_wr, out_br, out_illop}), 64'd0);
        check_eq("rst_lit", 64'(out_lit), 64'd0);
        check_eq("rst_pc", 64'(out_pc), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  op;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_valid   = 1'b0;
        m_ent     = '0;
        m_pc      = '0;
        #1;
        check_payload_zero();
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // ADDC R1,5,R2
        cycle(1'b1, 32'hC0410005, 32'h104, 1'b1, 1'b0);
        check_eq("addc_valid", 64'(out_valid), 64'd1);
        check_eq("addc_fn", 64'(out_fn), 64'h10);
        check_eq("addc_bsel", 64'(out_bsel), 64'd1);
        check_eq("addc_lit", 64'(out_lit), 64'h5);
        check_eq("addc_ra", 64'(out_ra), 64'd1);
        check_eq("addc_rc", 64'(out_rc), 64'd2);
        check_eq("addc_werf", 64'(out_werf), 64'd1);
        check_eq("addc_wdsel", 64'(out_wdsel), 64'd1);

        // SRA R3,R4,R5 back to back with the previous entry being consumed
        cycle(1'b1, 32'hB8A32000, 32'h108, 1'b1, 1'b0);
        check_eq("sra_fn", 64'(out_fn), 64'h33);
        check_eq("sra_bsel", 64'(out_bsel), 64'd0);
        check_eq("sra_ra", 64'(out_ra), 64'd3);
        check_eq("sra_rb", 64'(out_rb), 64'd4);
        check_eq("sra_rc", 64'(out_rc), 64'd5);

        // CMPLEC R0,-8,R1
        cycle(1'b1, 32'hD820FFF8, 32'h10C, 1'b1, 1'b0);
        check_eq("cmplec_fn", 64'(out_fn), 64'h07);
        check_eq("cmplec_lit", 64'(out_lit), 64'hFFFFFFF8);

        // ST R7,4(R2)
        cycle(1'b1, 32'h64E20004, 32'h110, 1'b1, 1'b0);
        check_eq("st_fn", 64'(out_fn), 64'h10);
        check_eq("st_mem_wr", 64'(out_mem_wr), 64'd1);
        check_eq("st_werf", 64'(out_werf), 64'd0);
        check_eq("st_rb", 64'(out_rb), 64'd7);

        // Backpressure: ST held for three cycles while IF keeps offering ADDC
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'hC0410005, 32'h114, 1'b0, 1'b0);
            check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            check_eq("bp_rb", 64'(out_rb), 64'd7);
            check_eq("bp_mem_wr", 64'(out_mem_wr), 64'd1);
        end

        // MUL is illegal and becomes a trap
        cycle(1'b1, 32'h88000000, 32'h118, 1'b1, 1'b0);
        check_eq("mul_illop", 64'(out_illop), 64'd1);
        check_eq("mul_rc", 64'(out_rc), 64'd30);
        check_eq("mul_werf", 64'(out_werf), 64'd1);
        check_eq("mul_wdsel", 64'(out_wdsel), 64'd0);

        // Flush with an entry held and an instruction on offer
        cycle(1'b1, 32'hC0410005, 32'h11C, 1'b0, 1'b0);
        cycle(1'b1, 32'hC0410005, 32'h120, 1'b1, 1'b1);
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_eq("flush_dropped", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges
        cycle(1'b1, 32'hC0410005, 32'h124, 1'b0, 1'b0);
        check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_payload_zero();
        in_valid = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        m_valid = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r  = $urandom;
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                             : 6'($urandom_range(24, 63));
            cycle(($urandom_range(0, 9) < 7), {op, r[25:0]}, $urandom,
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/beta_decode.md
# beta_decode

Register-file/decode stage of the pipelined Beta CPU: accepts a fetched 32-bit instruction and its PC from IF over a valid/ready handshake. It decodes the opcode into the 6-bit ALU function code and datapath selects, sign-extends the literal, and registers the result into a one-entry pipeline buffer. The ALU/EX stage drains that buffer through a second valid/ready handshake. Illegal opcodes become traps, and a flush input squashes the stage on a taken branch or exception.

## Interface
- PC_W, default 32: program-counter width.
- clk  in  1  system clock; every flop updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction: opcode[31:26], rc[25:21], ra[20:16], rb[15:11], lit[15:0].
- in_pc  in  PC_W  PC+4 of the instruction.
- flush  in  1  squash the buffered and the incoming instruction.
- out_valid  out  1  decoded entry available to EX.
- out_ready  in  1  EX consumes the entry.
- out_fn  out  6  ALU FN.
- out_bsel  out  1  ALU B source: 0 = register, 1 = literal.
- out_asel  out  1  ALU A source: 0 = register, 1 = PC-relative (LDR).
- out_ra, out_rb, out_rc  out  5 each  register addresses.
- out_lit  out  32  sign-extended lit.
- out_pc  out  PC_W  registered in_pc.
- out_werf  out  1  write register file.
- out_wdsel  out  2  write-back source: 0 = PC+4, 1 = ALU, 2 = MEM.
- out_mem_rd, out_mem_wr  out  1 each  load / store.
- out_br  out  2  branch type: 0 none, 1 JMP, 2 BEQ, 3 BNE.
- out_illop  out  1  illegal-opcode trap.

## Operation
- FN codes: CMPEQ 000011, CMPLT 000101, CMPLE 000111, ADD 010000, SUB 010001, SHL 110000, SHR 110001, SRA 110011, AFN 101010, AND 101000, OR 101110, XOR 100110.
- OP class (0x20–0x2F) selects bsel=0; OPC class (opcode+0x10) selects bsel=1. Both set werf=1 and wdsel=ALU.
- Opcode to FN mapping:
  - ADD 0x20, SUB 0x21 → ADD, SUB.
  - CMPEQ 0x24, CMPLT 0x25, CMPLE 0x26 → matching compare codes.
  - AND 0x28, OR 0x29, XOR 0x2A → AND, OR, XOR.
  - SHL 0x2C, SHR 0x2D, SRA 0x2E → SHL, SHR, SRA.
- LD 0x18: fn=ADD, bsel=1, mem_rd=1, werf=1, wdsel=MEM.
- ST 0x19: fn=ADD, bsel=1, mem_wr=1, werf=0, out_rb=rc.
- LDR 0x1F: fn=AFN, asel=1, mem_rd=1, werf=1, wdsel=MEM.
- JMP 0x1B, BEQ 0x1C, BNE 0x1D: fn=ADD, werf=1, wdsel=PC+4, br=1/2/3.
- Any other opcode is illegal, including MUL, DIV and XNOR. Result: illop=1, out_rc=30 (XP), werf=1, wdsel=PC+4, fn=ADD, mem_rd=mem_wr=0, br=0.
- out_lit = {{16{lit[15]}}, lit[15:0]} for every opcode. Register fields pass through unless overridden above.

## Timing
- Reset: out_valid=0 and every payload output 0 (out_fn=000000).
- in_ready = !out_valid || out_ready. It is combinational and ignores flush.
- Accept occurs when in_valid && in_ready && !flush: the entry loads on that edge and out_valid is 1 next cycle. Latency is 1 cycle.
- out_ready=1 with no accept: out_valid falls the next cycle.
- Simultaneous consume and accept: the new entry replaces the old one, giving one instruction per cycle at full throughput.
- out_valid=1 and out_ready=0: payload holds bit-stable and in_ready=0.
- flush has priority over everything: out_valid=0 next cycle, and any instruction offered that cycle is dropped. Payload registers may keep stale values.
- Reset asserted mid-operation clears out_valid immediately and asynchronously, without waiting for a clock edge.

## Structure
- beta_pkg holds:
  - the alu_fn_t enum, shared with alu;
  - opcode localparams;
  - the wdsel_t and br_t enums;
  - the XP register index constant (30).
- One sub-module, beta_op_decoder, is purely combinational: instruction → decoded control struct.
- beta_decode holds the handshake and pipeline register.

## Test plan
- ADDC R1,5,R2 (0xC0410005) accepted → next cycle out_valid=1, fn=010000, bsel=1, lit=0x00000005, ra=1, rc=2, werf=1, wdsel=1.
- SRA R3,R4,R5 (0xB8A32000) → fn=110011, bsel=0, ra=3, rb=4, rc=5.
- CMPLEC R0,-8,R1 (0xD820FFF8) → fn=000111, lit=0xFFFFFFF8.
- ST R7,4(R2) (0x64E20004) → fn=010000, mem_wr=1, werf=0, out_rb=7.
- Backpressure, illegal opcode and flush:
  - out_ready=0 for 3 cycles with an entry held → in_ready=0 and payload unchanged.
  - MUL (0x88000000) → illop=1, rc=30, werf=1, wdsel=0.
- Flush and reset:
  - flush=1 while out_valid=1 and in_valid=1 → out_valid=0 next cycle, and the incoming instruction never appears.
  - rst pulsed mid-stream → out_valid=0 with no clock edge.
